// File: rtl/decode_stage_p_if.sv
// Bundle of the decode stage's F/D inputs, W/forwarding inputs, redirect outputs and D/E payload.
// master = surrounding pipeline, slave = decode_stage_p.
interface decode_stage_p_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 3
);
  localparam int AW = $clog2(NREG);

  logic                 in_valid;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_instr;
  logic                 stall;
  logic                 flush;
  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic [XLEN-1:0]      w_data;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [XLEN-1:0]      d_rs_val;
  logic [XLEN-1:0]      d_rt_val;
  logic                 d_br_taken;
  logic [XLEN-1:0]      d_br_target;
  logic                 e_valid;
  logic [XLEN-1:0]      e_pc;
  logic [XLEN-1:0]      e_rs_val;
  logic [XLEN-1:0]      e_rt_val;
  logic [XLEN-1:0]      e_imm;
  logic [31:0]          e_instr;
  logic [AW-1:0]        e_rs;
  logic [AW-1:0]        e_rt;
  logic [AW-1:0]        e_rd;

  modport master (
    output in_valid, in_pc, in_instr, stall, flush, w_we, w_addr, w_data,
           fwd_valid, fwd_addr, fwd_data,
    input  d_rs_val, d_rt_val, d_br_taken, d_br_target, e_valid, e_pc,
           e_rs_val, e_rt_val, e_imm, e_instr, e_rs, e_rt, e_rd
  );

  modport slave (
    input  in_valid, in_pc, in_instr, stall, flush, w_we, w_addr, w_data,
           fwd_valid, fwd_addr, fwd_data,
    output d_rs_val, d_rt_val, d_br_taken, d_br_target, e_valid, e_pc,
           e_rs_val, e_rt_val, e_imm, e_instr, e_rs, e_rt, e_rd
  );
endinterface

// File: rtl/decode_stage_p.sv
// MIPS decode stage: GRF, prioritised operand forwarding, immediate extension, branch unit, D/E register.
// Define DECODE_GRF_BYPASS_EN to make a same-cycle W write visible at the GRF read port.
module decode_stage_p #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NFWD = 3
) (
  input  logic              clk,
  input  logic              reset,
  decode_stage_p_if.slave   bus
);
  localparam int AW = $clog2(NREG);

  function automatic logic [AW-1:0] reg_field(input logic [4:0] f);
    return AW'(f);
  endfunction

  // Source 0 is youngest, so scan from the oldest down and let lower indices overwrite.
  function automatic logic [XLEN-1:0] resolve(
    input logic [AW-1:0]        addr,
    input logic [XLEN-1:0]      grf_val,
    input logic [NFWD-1:0]      fv,
    input logic [NFWD*AW-1:0]   fa,
    input logic [NFWD*XLEN-1:0] fd
  );
    logic [XLEN-1:0] v;
    v = grf_val;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fv[i] && fa[i*AW +: AW] == addr) v = fd[i*XLEN +: XLEN];
    end
    if (addr == '0) v = '0;
    return v;
  endfunction

  logic [XLEN-1:0] grf_q [NREG];
  logic [XLEN-1:0] grf_d [NREG];

  logic [5:0]      op;
  logic [AW-1:0]   rs_a, rt_a, rd_a;
  logic [XLEN-1:0] rs_grf, rt_grf, rs_val, rt_val;
  logic [XLEN-1:0] pc4, imm, br_target;
  logic signed [XLEN-1:0] imm_sext;
  logic            br_hit, capture;

  logic            e_valid_q, e_valid_d;
  logic [XLEN-1:0] e_pc_q, e_pc_d, e_rs_val_q, e_rs_val_d, e_rt_val_q, e_rt_val_d;
  logic [XLEN-1:0] e_imm_q, e_imm_d;
  logic [31:0]     e_instr_q, e_instr_d;
  logic [AW-1:0]   e_rs_q, e_rs_d, e_rt_q, e_rt_d, e_rd_q, e_rd_d;

  assign op   = bus.in_instr[31:26];
  assign rs_a = reg_field(bus.in_instr[25:21]);
  assign rt_a = reg_field(bus.in_instr[20:16]);
  assign rd_a = reg_field(bus.in_instr[15:11]);

  always_comb begin
    grf_d = grf_q;
    if (bus.w_we && bus.w_addr != '0) grf_d[bus.w_addr] = bus.w_data;
  end

  always_comb begin
    rs_grf = grf_q[rs_a];
    rt_grf = grf_q[rt_a];
`ifdef DECODE_GRF_BYPASS_EN
    if (bus.w_we && bus.w_addr != '0 && bus.w_addr == rs_a) rs_grf = bus.w_data;
    if (bus.w_we && bus.w_addr != '0 && bus.w_addr == rt_a) rt_grf = bus.w_data;
`else
    rs_grf = rs_grf;
`endif
  end

  assign rs_val = resolve(rs_a, rs_grf, bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
  assign rt_val = resolve(rt_a, rt_grf, bus.fwd_valid, bus.fwd_addr, bus.fwd_data);

  always_comb begin
    imm_sext = XLEN'(signed'(bus.in_instr[15:0]));
    case (op)
      6'b001100, 6'b001101, 6'b001110: imm = XLEN'(bus.in_instr[15:0]);
      6'b001111:                       imm = XLEN'({bus.in_instr[15:0], 16'h0000});
      default:                         imm = imm_sext;
    endcase
  end

  always_comb begin
    pc4       = bus.in_pc + XLEN'(4);
    br_hit    = 1'b0;
    br_target = pc4;
    case (op)
      6'b000100: begin
        br_hit    = (rs_val == rt_val);
        br_target = pc4 + (imm_sext <<< 2);
      end
      6'b000101: begin
        br_hit    = (rs_val != rt_val);
        br_target = pc4 + (imm_sext <<< 2);
      end
      6'b000010, 6'b000011: begin
        br_hit    = 1'b1;
        br_target = {pc4[XLEN-1:28], bus.in_instr[25:0], 2'b00};
      end
      6'b000000: begin
        if (bus.in_instr[5:0] == 6'b001000) begin
          br_hit    = 1'b1;
          br_target = rs_val;
        end
      end
      default: ;
    endcase
  end

  assign capture = bus.in_valid && !bus.stall && !bus.flush;

  // D/E register: any non-capturing cycle loads an all-zero bubble.
  always_comb begin
    e_valid_d  = capture;
    e_pc_d     = '0;
    e_rs_val_d = '0;
    e_rt_val_d = '0;
    e_imm_d    = '0;
    e_instr_d  = '0;
    e_rs_d     = '0;
    e_rt_d     = '0;
    e_rd_d     = '0;
    if (capture) begin
      e_pc_d     = bus.in_pc;
      e_rs_val_d = rs_val;
      e_rt_val_d = rt_val;
      e_imm_d    = imm;
      e_instr_d  = bus.in_instr;
      e_rs_d     = rs_a;
      e_rt_d     = rt_a;
      e_rd_d     = rd_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_q      <= '{default: '0};
      e_valid_q  <= 1'b0;
      e_pc_q     <= '0;
      e_rs_val_q <= '0;
      e_rt_val_q <= '0;
      e_imm_q    <= '0;
      e_instr_q  <= '0;
      e_rs_q     <= '0;
      e_rt_q     <= '0;
      e_rd_q     <= '0;
    end else begin
      grf_q      <= grf_d;
      e_valid_q  <= e_valid_d;
      e_pc_q     <= e_pc_d;
      e_rs_val_q <= e_rs_val_d;
      e_rt_val_q <= e_rt_val_d;
      e_imm_q    <= e_imm_d;
      e_instr_q  <= e_instr_d;
      e_rs_q     <= e_rs_d;
      e_rt_q     <= e_rt_d;
      e_rd_q     <= e_rd_d;
    end
  end

  assign bus.d_rs_val    = rs_val;
  assign bus.d_rt_val    = rt_val;
  assign bus.d_br_taken  = br_hit && capture;
  assign bus.d_br_target = br_target;
  assign bus.e_valid     = e_valid_q;
  assign bus.e_pc        = e_pc_q;
  assign bus.e_rs_val    = e_rs_val_q;
  assign bus.e_rt_val    = e_rt_val_q;
  assign bus.e_imm       = e_imm_q;
  assign bus.e_instr     = e_instr_q;
  assign bus.e_rs        = e_rs_q;
  assign bus.e_rt        = e_rt_q;
  assign bus.e_rd        = e_rd_q;
endmodule
